// File: rtl/mem_access_pkg.sv
// Shared types and constants for the LEGv8 load/store sequencer.
package mem_access_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC_LO,
    ST_ACC_HI,
    ST_RCAP,
    ST_DONE
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int HI_OFFSET  = 4;

endpackage

// File: rtl/mem_lane_fmt.sv
// Lane formatting for the 32-bit data memory port: byte enables, store lane
// placement, and load extraction with zero/sign extension.
module mem_lane_fmt
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  size_e                 size,
  input  logic [1:0]            offset,
  input  logic                  is_signed,
  input  logic                  hi_word,
  input  logic [DATA_W-1:0]     store_data,
  input  logic [31:0]           read_word,
  input  logic [31:0]           lo_word,
  output logic [WORD_BYTES-1:0] byte_en,
  output logic [31:0]           write_word,
  output logic [DATA_W-1:0]     load_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted_rd;

  assign shamt      = {offset, 3'b000};
  assign shifted_rd = read_word >> shamt;

  always_comb begin
    byte_en    = '1;
    write_word = store_data[31:0];
    load_data  = '0;
    case (size)
      SZ_B: begin
        byte_en    = WORD_BYTES'(1) << offset;
        write_word = {24'b0, store_data[7:0]} << shamt;
        load_data  = {{(DATA_W-8){is_signed & shifted_rd[7]}}, shifted_rd[7:0]};
      end
      SZ_H: begin
        byte_en    = WORD_BYTES'(3) << offset;
        write_word = {16'b0, store_data[15:0]} << shamt;
        load_data  = {{(DATA_W-16){is_signed & shifted_rd[15]}}, shifted_rd[15:0]};
      end
      SZ_W: begin
        load_data  = {{(DATA_W-32){is_signed & shifted_rd[31]}}, shifted_rd};
      end
      SZ_D: begin
        // The high word arrives last, so read_word is the upper half here.
        write_word = hi_word ? store_data[63:32] : store_data[31:0];
        load_data  = DATA_W'({read_word, lo_word});
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the LEGv8 datapath and a 32-bit data memory.
// Define MEM_ACCESS_FAULT_EN to enable alignment/illegal-request faults.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iMemRead,
  input  logic                  iMemWrite,
  input  logic [1:0]            iSize,
  input  logic                  iSigned,
  input  logic [ADDR_W-1:0]     iAddress,
  input  logic [DATA_W-1:0]     iStoreData,
  input  logic [DATA_W-1:0]     wReadData,
  output logic                  wReadEnable,
  output logic                  wWriteEnable,
  output logic [WORD_BYTES-1:0] wByteEnable,
  output logic [ADDR_W-1:0]     wAddress,
  output logic [DATA_W-1:0]     wWriteData,
  output logic [DATA_W-1:0]     oLoadData,
  output logic                  oStall,
  output logic                  oDone,
  output logic                  oFault
);

  state_e              state_q, state_d;
  size_e               size_q, req_size;
  logic                signed_q, write_q;
  logic [ADDR_W-1:0]   addr_q, req_addr, word_addr;
  logic [DATA_W-1:0]   data_q;
  logic [31:0]         lo_q;
  logic                req, req_write, illegal, hi_sel;
  logic [WORD_BYTES-1:0] fmt_be;
  logic [31:0]         fmt_wr;
  logic [DATA_W-1:0]   fmt_load;
  logic                unused_read;

  assign req         = iMemRead | iMemWrite;
  assign req_size    = size_e'(iSize);
  assign req_write   = iMemWrite;
  assign word_addr   = {addr_q[ADDR_W-1:2], 2'b00};
  assign hi_sel      = (state_q == ST_ACC_HI);
  assign oStall      = ~iRST & req & (state_q != ST_DONE);
  assign unused_read = ^wReadData[DATA_W-1:32];

`ifdef MEM_ACCESS_FAULT_EN
  logic fault_q;

  always_comb begin
    illegal  = iMemRead & iMemWrite;
    req_addr = iAddress;
    case (req_size)
      SZ_H:       illegal = illegal | iAddress[0];
      SZ_W, SZ_D: illegal = illegal | (|iAddress[1:0]);
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fault_q <= 1'b0;
    end else if (state_q == ST_IDLE && req) begin
      fault_q <= illegal;
    end
  end

  assign oFault = (state_q == ST_DONE) & fault_q;
`else
  // Without fault checking, misaligned addresses are forced to natural alignment.
  always_comb begin
    illegal  = 1'b0;
    req_addr = iAddress;
    case (req_size)
      SZ_H:       req_addr[0]   = 1'b0;
      SZ_W, SZ_D: req_addr[1:0] = 2'b00;
      default: ;
    endcase
  end

  assign oFault = 1'b0;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= ST_IDLE;
      size_q    <= SZ_B;
      signed_q  <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      lo_q      <= '0;
      oLoadData <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        size_q   <= req_size;
        signed_q <= iSigned;
        write_q  <= req_write;
        addr_q   <= req_addr;
        data_q   <= iStoreData;
        if (illegal && iMemRead) oLoadData <= '0;
      end
      if (state_q == ST_ACC_HI) lo_q <= wReadData[31:0];
      if (state_q == ST_RCAP) oLoadData <= fmt_load;
    end
  end

  // Memory strobes are gated by reset so an abort never issues a stray access.
  always_comb begin
    state_d      = state_q;
    wReadEnable  = 1'b0;
    wWriteEnable = 1'b0;
    wByteEnable  = '0;
    wAddress     = '0;
    wWriteData   = '0;
    oDone        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = illegal ? ST_DONE : ST_ACC_LO;
      end
      ST_ACC_LO: begin
        wAddress     = word_addr;
        wByteEnable  = fmt_be;
        wReadEnable  = ~write_q & ~iRST;
        wWriteEnable = write_q & ~iRST;
        if (write_q) wWriteData = {{(DATA_W-32){1'b0}}, fmt_wr};
        if (size_q == SZ_D) state_d = ST_ACC_HI;
        else                state_d = write_q ? ST_DONE : ST_RCAP;
      end
      ST_ACC_HI: begin
        wAddress     = word_addr + ADDR_W'(HI_OFFSET);
        wByteEnable  = fmt_be;
        wReadEnable  = ~write_q & ~iRST;
        wWriteEnable = write_q & ~iRST;
        if (write_q) wWriteData = {{(DATA_W-32){1'b0}}, fmt_wr};
        state_d = write_q ? ST_DONE : ST_RCAP;
      end
      ST_RCAP: state_d = ST_DONE;
      ST_DONE: begin
        oDone   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mem_lane_fmt #(.DATA_W(DATA_W)) u_fmt (
    .size       (size_q),
    .offset     (addr_q[1:0]),
    .is_signed  (signed_q),
    .hi_word    (hi_sel),
    .store_data (data_q),
    .read_word  (wReadData[31:0]),
    .lo_word    (lo_q),
    .byte_en    (fmt_be),
    .write_word (fmt_wr),
    .load_data  (fmt_load)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-wide data memory model.
// Expectations follow MEM_ACCESS_FAULT_EN when it is defined.
module tb_mem_access_unit;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic        iMemRead, iMemWrite, iSigned;
  logic [1:0]  iSize;
  logic [63:0] iAddress, iStoreData, wReadData;
  logic        wReadEnable, wWriteEnable;
  logic [3:0]  wByteEnable;
  logic [63:0] wAddress, wWriteData, oLoadData;
  logic        oStall, oDone, oFault;

  int passed = 0;
  int total  = 0;
  int stall_bad = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int lat, lat2, r0, w0;
  logic fault_seen;

  logic        mem_init;
  logic [31:0] mem [16];
  logic [63:0] rdata_q = '0;
  logic [63:0] wlog_addr [16];
  logic [63:0] wlog_data [16];
  logic [3:0]  wlog_be   [16];
  logic [63:0] rd_addr_last;
  logic [3:0]  rd_be_last;

  always #5 iCLK = ~iCLK;

  mem_access_unit #(.ADDR_W(64), .DATA_W(64)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iMemRead     (iMemRead),
    .iMemWrite    (iMemWrite),
    .iSize        (iSize),
    .iSigned      (iSigned),
    .iAddress     (iAddress),
    .iStoreData   (iStoreData),
    .wReadData    (wReadData),
    .wReadEnable  (wReadEnable),
    .wWriteEnable (wWriteEnable),
    .wByteEnable  (wByteEnable),
    .wAddress     (wAddress),
    .wWriteData   (wWriteData),
    .oLoadData    (oLoadData),
    .oStall       (oStall),
    .oDone        (oDone),
    .oFault       (oFault)
  );

  assign wReadData = rdata_q;

  // Memory: writes land on the edge, read data is valid the following cycle.
  always @(posedge iCLK) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h8001_1234;
      mem[1] <= 32'hCAFE_F00D;
    end else begin
      if (wWriteEnable)
        for (int b = 0; b < 4; b++)
          if (wByteEnable[b]) mem[wAddress[5:2]][8*b +: 8] <= wWriteData[8*b +: 8];
      if (wReadEnable) rdata_q <= {32'h0, mem[wAddress[5:2]]};
    end
  end

  always @(negedge iCLK) begin
    if (wWriteEnable) begin
      wlog_addr[wr_cnt % 16] = wAddress;
      wlog_data[wr_cnt % 16] = wWriteData;
      wlog_be[wr_cnt % 16]   = wByteEnable;
      wr_cnt++;
    end
    if (wReadEnable) begin
      rd_addr_last = wAddress;
      rd_be_last   = wByteEnable;
      rd_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Call aligned 1 time unit after a rising edge; returns aligned the same way
  // right after the DONE edge, with the request still driven.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic sgn, input logic [63:0] addr,
                               input logic [63:0] data, output int latency);
    iMemRead   = rd;
    iMemWrite  = wr;
    iSize      = sz;
    iSigned    = sgn;
    iAddress   = addr;
    iStoreData = data;
    latency    = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge iCLK);
      if (oDone) begin
        if (oStall) stall_bad++;
        fault_seen = oFault;
        latency    = c;
        break;
      end else if (!oStall) begin
        stall_bad++;
      end
    end
    @(posedge iCLK);
    #1;
  endtask

  task automatic clearReq();
    iMemRead   = 1'b0;
    iMemWrite  = 1'b0;
    iSize      = 2'b00;
    iSigned    = 1'b0;
    iAddress   = '0;
    iStoreData = '0;
    @(posedge iCLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, 64'({oDone, oFault, oStall, wReadEnable, wWriteEnable, wByteEnable}), 64'h0);
    checkOutput({tag, "_addr"}, wAddress, 64'h0);
    checkOutput({tag, "_wdata"}, wWriteData, 64'h0);
    checkOutput({tag, "_load"}, oLoadData, 64'h0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    iRST = 1'b1;
    mem_init = 1'b1;
    iMemRead = 1'b0; iMemWrite = 1'b0; iSize = 2'b00; iSigned = 1'b0;
    iAddress = '0; iStoreData = '0;
    repeat (2) @(posedge iCLK);
    @(negedge iCLK);
    checkAllZero("reset");
    @(posedge iCLK);
    #1;
    iRST = 1'b0;
    mem_init = 1'b0;
    @(negedge iCLK);
    checkAllZero("post_reset");
    @(posedge iCLK);
    #1;

    $display("[TB] LDURH signed @0x1002");
    r0 = rd_cnt; w0 = wr_cnt;
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 64'h1002, 64'h0, lat);
    checkOutput("ldurh_lat", 64'(lat), 64'd3);
    checkOutput("ldurh_reads", 64'(rd_cnt - r0), 64'd1);
    checkOutput("ldurh_writes", 64'(wr_cnt - w0), 64'd0);
    checkOutput("ldurh_be", 64'(rd_be_last), 64'hC);
    checkOutput("ldurh_addr", rd_addr_last, 64'h1000);
    checkOutput("ldurh_data", oLoadData, 64'hFFFF_FFFF_FFFF_8001);
    clearReq();

    $display("[TB] STURB @0x1003");
    w0 = wr_cnt;
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 64'h1003, 64'hAB, lat);
    checkOutput("sturb_lat", 64'(lat), 64'd2);
    checkOutput("sturb_writes", 64'(wr_cnt - w0), 64'd1);
    checkOutput("sturb_be", 64'(wlog_be[w0 % 16]), 64'h8);
    checkOutput("sturb_wdata", wlog_data[w0 % 16], 64'hAB00_0000);
    checkOutput("sturb_addr", wlog_addr[w0 % 16], 64'h1000);
    checkOutput("sturb_fault", 64'(fault_seen), 64'd0);
    clearReq();

    $display("[TB] STUR dword @0x1008");
    w0 = wr_cnt;
    applyStimulus(1'b0, 1'b1, 2'b11, 1'b0, 64'h1008, 64'h1122_3344_5566_7788, lat);
    checkOutput("stur_lat", 64'(lat), 64'd3);
    checkOutput("stur_writes", 64'(wr_cnt - w0), 64'd2);
    checkOutput("stur_lo_addr", wlog_addr[w0 % 16], 64'h1008);
    checkOutput("stur_lo_data", wlog_data[w0 % 16], 64'h5566_7788);
    checkOutput("stur_hi_addr", wlog_addr[(w0 + 1) % 16], 64'h100C);
    checkOutput("stur_hi_data", wlog_data[(w0 + 1) % 16], 64'h1122_3344);
    checkOutput("stur_hi_be", 64'(wlog_be[(w0 + 1) % 16]), 64'hF);
    clearReq();

    $display("[TB] LDUR dword @0x1008");
    r0 = rd_cnt;
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 64'h1008, 64'h0, lat);
    checkOutput("ldur_lat", 64'(lat), 64'd4);
    checkOutput("ldur_reads", 64'(rd_cnt - r0), 64'd2);
    checkOutput("ldur_data", oLoadData, 64'h1122_3344_5566_7788);
    clearReq();

    $display("[TB] LDURSW @0x1006");
    r0 = rd_cnt; w0 = wr_cnt;
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b1, 64'h1006, 64'h0, lat);
`ifdef MEM_ACCESS_FAULT_EN
    checkOutput("ldursw_lat", 64'(lat), 64'd1);
    checkOutput("ldursw_fault", 64'(fault_seen), 64'd1);
    checkOutput("ldursw_reads", 64'(rd_cnt - r0), 64'd0);
    checkOutput("ldursw_writes", 64'(wr_cnt - w0), 64'd0);
    checkOutput("ldursw_data", oLoadData, 64'h0);
`else
    checkOutput("ldursw_lat", 64'(lat), 64'd3);
    checkOutput("ldursw_fault", 64'(fault_seen), 64'd0);
    checkOutput("ldursw_reads", 64'(rd_cnt - r0), 64'd1);
    checkOutput("ldursw_addr", rd_addr_last, 64'h1004);
    checkOutput("ldursw_data", oLoadData, 64'hFFFF_FFFF_CAFE_F00D);
`endif
    clearReq();

    $display("[TB] back-to-back LDURB @0x1000, STURB @0x1001");
    w0 = wr_cnt;
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 64'h1000, 64'h0, lat);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0, 64'h1001, 64'h5A, lat2);
    checkOutput("b2b_ld_lat", 64'(lat), 64'd3);
    checkOutput("b2b_ld_data", oLoadData, 64'h34);
    checkOutput("b2b_st_lat", 64'(lat2), 64'd2);
    checkOutput("b2b_st_be", 64'(wlog_be[w0 % 16]), 64'h2);
    checkOutput("b2b_st_wdata", wlog_data[w0 % 16], 64'h5A00);
    clearReq();
    checkOutput("b2b_mem_word", 64'(mem[0]), 64'hAB01_5A34);

    $display("[TB] reset during ACC_HI of dword store @0x1010");
    w0 = wr_cnt;
    iMemWrite  = 1'b1;
    iSize      = 2'b11;
    iAddress   = 64'h1010;
    iStoreData = 64'hDEAD_BEEF_0102_0304;
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    iRST = 1'b1;
    @(negedge iCLK);
    checkOutput("abort_hi_we", 64'(wWriteEnable), 64'd0);
    @(posedge iCLK); #1;
    iRST = 1'b0;
    iMemWrite = 1'b0; iSize = 2'b00; iAddress = '0; iStoreData = '0;
    @(negedge iCLK);
    checkAllZero("abort");
    @(posedge iCLK); #1;
    checkOutput("abort_writes", 64'(wr_cnt - w0), 64'd1);
    checkOutput("abort_lo_word", 64'(mem[4]), 64'h0102_0304);
    checkOutput("abort_hi_word", 64'(mem[5]), 64'h0);

    $display("[TB] LDURB @0x1010 after abort");
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 64'h1010, 64'h0, lat);
    checkOutput("post_abort_lat", 64'(lat), 64'd3);
    checkOutput("post_abort_data", oLoadData, 64'h04);
    clearReq();

    checkOutput("stall_profile", 64'(stall_bad), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the LEGv8 datapath and the data memory. Converts LDUR/LDURSW/LDURH/LDURB and STUR/STURW/STURH/STURB requests into accesses on the 32-bit-word, 4-byte-enable data memory port. It splits doubleword accesses into two word accesses, places store bytes on the correct lanes, and extracts and extends load data. It stalls the core until the access completes.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, core data width

Ports:
- iCLK  in  1  core clock
- iRST  in  1  synchronous, active-high reset
- iMemRead  in  1  load request, held by core until oDone
- iMemWrite  in  1  store request, held by core until oDone
- iSize  in  2  00 byte, 01 half, 10 word, 11 dword
- iSigned  in  1  sign-extend load (LDURSW); ignored for stores and dword
- iAddress  in  64  byte address
- iStoreData  in  64  store data, right-aligned
- wReadData  in  64  data memory read data; bits [31:0] valid
- wReadEnable  out  1  to data memory
- wWriteEnable  out  1  to data memory
- wByteEnable  out  4  to data memory
- wAddress  out  64  word-aligned byte address to data memory
- wWriteData  out  64  lane-positioned data in [31:0]; [63:32] zero
- oLoadData  out  64  extended load result
- oStall  out  1  hold PC and register write
- oDone  out  1  one-cycle completion pulse
- oFault  out  1  alignment/illegal fault, valid with oDone

## Operation
- States: IDLE, ACC_LO, ACC_HI, RCAP, DONE.
- IDLE, request present: latch size, signed, address, data, and direction.
  - Legal request: go to ACC_LO.
  - Illegal request: go to DONE with oFault=1 and no memory access.
- Illegal cases:
  - iMemRead and iMemWrite both high.
  - Half at an odd address.
  - Word or dword with iAddress[1:0]≠0.
- ACC_LO: wAddress={A[63:2],2'b00}.
  - Dword: go to ACC_HI.
  - Otherwise: loads go to RCAP, stores go to DONE.
- ACC_HI: wAddress is the ACC_LO address +4, byte enables 1111, store data iStoreData[63:32]. The low-word read data is captured into lo_q. Loads go to RCAP, stores go to DONE.
- RCAP: capture the read data (the high word for dword, the only word otherwise). Go to DONE.
- DONE: oDone=1, oStall=0. Go to IDLE unconditionally. The core advances on this edge, so the same request is never re-accepted.
- Byte enables: byte 0001<<A[1:0]; half 0011<<A[1:0]; word and dword 1111.
- Store lanes: the byte/half is shifted left by 8·A[1:0] into wWriteData[31:0].
- Load extract: shift right by 8·A[1:0], mask to size. Zero-extend unless iSigned, in which case replicate the top bit of the accessed size. Dword result = {hi, lo_q}.
- wReadEnable and wWriteEnable are asserted only in ACC_LO and ACC_HI, each exactly one iCLK cycle per word. No double writes.
- oStall = ~iRST & (iMemRead|iMemWrite) & (state≠DONE).
- oLoadData holds its last value until the next load's RCAP. It is 0 after reset and on faulted loads.

## Timing
- Request seen in cycle N.
- Memory read data is valid in the cycle after the issuing cycle.
- Completion (oDone) cycle:
  - Byte/half/word load: N+3.
  - Dword load: N+4.
  - Byte/half/word store: N+2.
  - Dword store: N+3.
  - Fault: N+1.
- Reset: state IDLE; all outputs 0 (oLoadData, oDone, oFault, oStall, enables, wAddress, wWriteData).
- Reset during ACC_HI of a dword store aborts it. The low word stays written; accepted.
- Requests arriving in DONE are ignored until IDLE.

## Configuration
- MEM_ACCESS_FAULT_EN defined: alignment/illegal checks as above; oFault driven.
- Undefined: no checks, and oFault is tied 0.
  - Address low bits are masked to the natural alignment of the size (half clears bit 0; word/dword clear bits [1:0]).
  - Read and write both high is treated as a write.

## Structure
- Package mem_access_pkg holds:
  - size enum (SZ_B, SZ_H, SZ_W, SZ_D)
  - state enum
  - WORD_BYTES=4
  - HI_OFFSET=4
- Sub-module mem_lane_fmt (combinational): byte-enable generation, store lane shift, load extract and extension.
- The FSM and latches live in mem_access_unit.

## Test plan
- STURB, A=0x1003, data 0xAB → one write, wByteEnable=1000, wWriteData[31:24]=0xAB, oDone at N+2.
- LDURH signed, A=0x1002, memory word 0x8001_1234 → wByteEnable=1100, oLoadData=0xFFFF_FFFF_FFFF_8001, oDone at N+3.
- STUR then LDUR dword at 0x1008, data 0x1122334455667788 → writes 0x55667788 @0x1008 then 0x11223344 @0x100C; read returns the original; load oDone at N+4.
- LDURSW at A=0x1006 with MEM_ACCESS_FAULT_EN → no enables asserted, oFault=1, oDone at N+1. Same stimulus without the macro → word read at 0x1004.
- Assert iRST during ACC_HI of a dword store → next cycle all outputs 0, state IDLE, no second write.
- Back-to-back LDURB 0x1000 then STURB 0x1001 → second access starts the cycle after the first DONE; stall deasserted only in DONE cycles.
